// File: rtl/uncached_store_buffer_if.sv
// rtl/uncached_store_buffer_if.sv - CPU-side and store-engine-side signals of the uncached store buffer.
// The master view drives CPU requests and engine status; the slave view is the buffer itself.
interface uncached_store_buffer_if;
    logic        cpu_uncached;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byte_enable;
    logic [31:0] cpu_wdata;
    logic        pipe_stall;
    logic        cpu_stall;
    logic        buf_empty;
    logic        sb_uncached;
    logic        sb_we;
    logic [31:0] sb_addr;
    logic [3:0]  sb_byte_enable;
    logic [31:0] sb_wdata;
    logic        sb_stall;

    modport master (
        output cpu_uncached, cpu_we, cpu_re, cpu_addr, cpu_byte_enable, cpu_wdata,
        output pipe_stall, sb_stall,
        input  cpu_stall, buf_empty, sb_uncached, sb_we, sb_addr, sb_byte_enable, sb_wdata
    );

    modport slave (
        input  cpu_uncached, cpu_we, cpu_re, cpu_addr, cpu_byte_enable, cpu_wdata,
        input  pipe_stall, sb_stall,
        output cpu_stall, buf_empty, sb_uncached, sb_we, sb_addr, sb_byte_enable, sb_wdata
    );
endinterface

// File: rtl/uncached_store_buffer.sv
// rtl/uncached_store_buffer.sv - posted-write FIFO feeding the uncached store AXI engine.
// Buffers uncached stores in order and issues them one at a time to the store engine.
module uncached_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uncached_store_buffer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    state_t           state;
    logic [31:0]      addrMem [DEPTH];
    logic [3:0]       beMem   [DEPTH];
    logic [31:0]      dataMem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   countNext;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign push  = bus.cpu_uncached & bus.cpu_we & ~full & ~bus.pipe_stall;
    assign pop   = (state == S_WAIT) & ~bus.sb_stall;

    always_comb begin
        countNext = count;
        if (push && !pop) begin
            countNext = count + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            countNext = count - (PTR_W+1)'(1);
        end
    end

    // A store arriving while idle becomes the head and issues on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            count <= countNext;
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (countNext != '0) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.sb_stall) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pop) begin
                        state <= (countNext != '0) ? S_ISSUE : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[wrPtr] <= bus.cpu_addr;
            beMem[wrPtr]   <= bus.cpu_byte_enable;
            dataMem[wrPtr] <= bus.cpu_wdata;
        end
    end

    // Stall decisions use the registered count only; a pop never frees a slot in the same cycle.
    assign bus.cpu_stall = (bus.cpu_uncached & bus.cpu_we & full)
                         | (bus.cpu_uncached & bus.cpu_re & (~empty | (state != S_IDLE)));
    assign bus.buf_empty      = empty & (state == S_IDLE);
    assign bus.sb_we          = (state == S_ISSUE);
    assign bus.sb_uncached    = (state == S_ISSUE);
    assign bus.sb_addr        = addrMem[rdPtr];
    assign bus.sb_byte_enable = beMem[rdPtr];
    assign bus.sb_wdata       = dataMem[rdPtr];
endmodule

// File: doc/uncached_store_buffer.md
Name: uncached_store_buffer

Overview:
- Posted-write FIFO in the MEM stage, directly upstream of the uncached store AXI engine.
- Accepts CPU uncached stores without stalling the pipeline, holds them in order, and presents them one at a time on the store engine's CPU-side interface.
- Stalls the CPU only when the FIFO is full, or when an uncached load must wait for older stores to drain.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width. Count width is PTR_W+1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_uncached  in  1  MEM-stage access is uncached.
- cpu_we  in  1  MEM-stage access is a store.
- cpu_re  in  1  MEM-stage access is a load.
- cpu_addr  in  32  store address (byte address).
- cpu_byte_enable  in  4  store byte strobes.
- cpu_wdata  in  32  store data, already lane-aligned.
- pipe_stall  in  1  pipeline held by another source this cycle; blocks enqueue.
- cpu_stall  out  1  buffer-induced pipeline stall.
- buf_empty  out  1  no stores pending or in flight.
- sb_uncached  out  1  to store engine: access is uncached.
- sb_we  out  1  to store engine: issue strobe.
- sb_addr  out  32  head entry address.
- sb_byte_enable  out  4  head entry strobes.
- sb_wdata  out  32  head entry data.
- sb_stall  in  1  store engine busy; high from the cycle after acceptance until it returns idle.

Behaviour:
- Storage: DEPTH entries of {addr, byte_enable, wdata}; registers wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- Enqueue (push) = cpu_uncached & cpu_we & !full & !pipe_stall. Push writes the entry at wr_ptr and increments wr_ptr.
- cpu_stall = (cpu_uncached & cpu_we & full) | (cpu_uncached & cpu_re & (!empty | state!=S_IDLE)).
  - Decided: cpu_stall depends on registered count only.
  - No bypass: when the FIFO is full and a pop happens in the same cycle, the store still stalls that cycle and is accepted the next cycle.
- Cached accesses never stall and never enqueue.
- buf_empty = empty & (state==S_IDLE).
- The FIFO is not emptied on the pop cycle; the head stays valid until it is popped.
- FSM states:
  - S_IDLE: sb_we=0. If !empty, go to S_ISSUE next cycle. Minimum latency from push to sb_we=1 is 1 cycle.
  - S_ISSUE: sb_we=1 and sb_uncached=1. Stay in S_ISSUE while sb_stall=0. When sb_stall=1, go to S_WAIT.
  - S_WAIT: sb_we=0; head data held stable. When sb_stall=0, pop (rd_ptr++, count--). Next state is S_ISSUE if count-1>0 (counting any same-cycle push), else S_IDLE.
- sb_we and sb_uncached are combinational decodes of state; they are high only in S_ISSUE.
- sb_addr, sb_byte_enable and sb_wdata are always driven from the entry at rd_ptr, and stay constant from S_ISSUE entry until the pop.
- The engine therefore sees exactly one issue per entry. sb_we=0 in the cycle the engine returns idle, so there is no duplicate write.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Push while empty and idle: the entry becomes the head and S_ISSUE starts next cycle.
- Reset: asynchronous on rst_n low, taking effect immediately.
  - state=S_IDLE; wr_ptr, rd_ptr and count are 0.
  - Outputs: cpu_stall=0 unless inputs demand it, buf_empty=1, sb_we=0, sb_uncached=0.
  - sb_addr, sb_byte_enable and sb_wdata show entry 0, which is don't-care.
  - Reset mid-operation discards all pending stores; the store engine shares rst_n.
- Ordering: strict FIFO; no merging or coalescing of stores to the same address.

Test Plan:
- Single store, addr 0x1FAF_F000, be 0xF, data 0xDEAD_BEEF, engine model with stall high 5 cycles -> cpu_stall=0 throughout; sb_we=1 for exactly the cycles before sb_stall rises; pop when stall falls; buf_empty=1 after.
- 5 back-to-back stores (data 0..4) with engine stall of 8 cycles each -> first 4 accepted, 5th stalls until the first pop (+1 cycle); engine receives 0,1,2,3,4 in order, each issued once.
- Uncached load while 2 stores pending -> cpu_stall=1 until buf_empty=1, then 0 that same cycle.
- Full FIFO, store presented on the pop cycle -> stalled that cycle, accepted next; count returns to 4; no entry lost or duplicated.
- pipe_stall=1 for 3 cycles with a store held on the inputs -> count unchanged; exactly one push on the first cycle pipe_stall=0.
- Assert rst_n low during S_WAIT with 3 entries pending -> outputs immediately return to reset values, buf_empty=1; no sb_we after release until a new push.
